// File: rtl/trig_align_pkg.sv
// Shared widths, the tracker state type, and phase-index helpers for the
// oversampling phase tracker.
package trig_align_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    TRACK = 1'b0,
    SHIFT = 1'b1
  } track_state_t;

  function automatic int phase_w(input int nphase);
    return $clog2(nphase);
  endfunction

  function automatic bit nphase_legal(input int nphase);
    return (nphase == 4) || (nphase == 8);
  endfunction

endpackage

// File: rtl/oversample_edge_detect.sv
// Two-stage sample pipeline. Stage 1 captures a bit period of samples, and
// stage 2 holds that word together with its transition vector.
module oversample_edge_detect
  import trig_align_pkg::*;
#(
  parameter int NPHASE = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NPHASE-1:0] samples,
  input  logic              samples_valid,
  output logic [NPHASE-1:0] s2,
  output logic [NPHASE-1:0] edges,
  output logic              valid2
);

  logic [NPHASE-1:0] s1_reg;
  logic [NPHASE-1:0] edge_comb;
  logic              prev_bit_reg;
  logic              valid1_reg;

  // Bit 0 is compared with the last sample of the previous bit period.
  assign edge_comb[0] = s1_reg[0] ^ prev_bit_reg;

  for (genvar gi = 1; gi < NPHASE; gi++) begin : g_edge
    assign edge_comb[gi] = s1_reg[gi] ^ s1_reg[gi-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg       <= '0;
      prev_bit_reg <= 1'b0;
      valid1_reg   <= 1'b0;
      s2           <= '0;
      edges        <= '0;
      valid2       <= 1'b0;
    end else begin
      valid1_reg <= samples_valid;
      valid2     <= valid1_reg;
      if (samples_valid) begin
        s1_reg       <= samples;
        prev_bit_reg <= s1_reg[NPHASE-1];
      end
      if (valid1_reg) begin
        s2    <= s1_reg;
        edges <= edge_comb;
      end
    end
  end

endmodule

// File: rtl/oversample_phase_tracker.sv
// Selects one oversampled phase as the recovered bit. When transitions keep
// landing next to that phase, the selection steps away from them.
module oversample_phase_tracker
  import trig_align_pkg::*;
#(
  parameter int NPHASE        = 8,
  parameter int ERR_THRESH    = 255,
  parameter int STABLE_THRESH = 63,
  parameter bit INVERT        = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NPHASE-1:0]          samples,
  input  logic                       samples_valid,
  input  logic                       manual_mode,
  input  logic [phase_w(NPHASE)-1:0] phase_sel_in,
  input  logic                       shift_count_clr,
  output logic                       data_out,
  output logic                       data_valid,
  output logic [phase_w(NPHASE)-1:0] phase_sel_out,
  output logic                       phase_err,
  output logic                       locked,
  output logic [CNT_W-1:0]           shift_count
);

  localparam int PW = phase_w(NPHASE);
  localparam logic [CNT_W-1:0] ERR_T    = CNT_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] STABLE_T = CNT_W'(STABLE_THRESH);

  if (!nphase_legal(NPHASE)) begin : g_bad_nphase
    $error("oversample_phase_tracker: NPHASE must be 4 or 8");
  end
  if (ERR_THRESH < 1 || ERR_THRESH > 255 || STABLE_THRESH < 1 || STABLE_THRESH > 255) begin : g_bad_thresh
    $error("oversample_phase_tracker: thresholds must be within 1..255");
  end

  logic [NPHASE-1:0] s2;
  logic [NPHASE-1:0] edges;
  logic              valid2;

  logic [PW-1:0]     p_reg, p_next, p_inc, p_dec;
  logic [CNT_W-1:0]  err_reg, err_next;
  logic [CNT_W-1:0]  stable_reg, stable_next;
  logic [CNT_W-1:0]  shift_reg, shift_next;
  logic              manual_prev_reg;
  track_state_t      state_reg, state_next;
  logic              edge_lo, edge_hi, shift_up, shift_dn;

  oversample_edge_detect #(.NPHASE(NPHASE)) u_edge_detect (
    .clock         (clock),
    .reset_n       (reset_n),
    .samples       (samples),
    .samples_valid (samples_valid),
    .s2            (s2),
    .edges         (edges),
    .valid2        (valid2)
  );

  // NPHASE is a power of two, so plain PW-bit arithmetic gives the modulo wrap.
  assign p_inc   = p_reg + 1'b1;
  assign p_dec   = p_reg - 1'b1;
  assign edge_lo = edges[p_reg];
  assign edge_hi = edges[p_inc];

  assign phase_err     = valid2 & (edge_lo | edge_hi);
  assign locked        = (stable_reg == STABLE_T);
  assign data_valid    = valid2;
  assign data_out      = valid2 & (s2[p_reg] ^ INVERT);
  assign phase_sel_out = p_reg;
  assign shift_count   = shift_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= TRACK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = (err_next == ERR_T) ? SHIFT : TRACK;
  end

  // When the selected phase's own edge is set, step later; that also covers both edges set.
  always_comb begin
    shift_up = 1'b0;
    shift_dn = 1'b0;
    if (state_reg == SHIFT && !manual_mode && valid2) begin
      shift_up = edge_lo;
      shift_dn = !edge_lo && edge_hi;
    end
  end

  always_comb begin
    p_next = p_reg;
    if (manual_mode)   p_next = phase_sel_in;
    else if (shift_up) p_next = p_inc;
    else if (shift_dn) p_next = p_dec;

    err_next = err_reg;
    if (locked || (p_next != p_reg) || (manual_prev_reg && !manual_mode))
      err_next = '0;
    else if (phase_err && err_reg < ERR_T)
      err_next = err_reg + 1'b1;

    stable_next = stable_reg;
    if (phase_err)
      stable_next = '0;
    else if (valid2 && stable_reg < STABLE_T)
      stable_next = stable_reg + 1'b1;

    shift_next = shift_reg;
    if (shift_count_clr)
      shift_next = '0;
    else if ((shift_up || shift_dn) && shift_reg != CNT_MAX)
      shift_next = shift_reg + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_reg           <= '0;
      err_reg         <= '0;
      stable_reg      <= '0;
      shift_reg       <= '0;
      manual_prev_reg <= 1'b0;
    end else begin
      p_reg           <= p_next;
      err_reg         <= err_next;
      stable_reg      <= stable_next;
      shift_reg       <= shift_next;
      manual_prev_reg <= manual_mode;
    end
  end

endmodule

// File: tb/tb_oversample_phase_tracker.sv
// Directed and randomized stimulus for oversample_phase_tracker. The expected
// values come from a serial-stream reference model.
module tb_oversample_phase_tracker;

  localparam int NP = 8;
  localparam int ET = 3;
  localparam int ST = 15;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] samples;
  logic       samples_valid;
  logic       manual_mode;
  logic [2:0] phase_sel_in;
  logic       shift_count_clr;
  logic       data_out, data_valid, phase_err, locked;
  logic [2:0] phase_sel_out;
  logic [7:0] shift_count;

  int errors = 0;
  int checks = 0;

  oversample_phase_tracker #(
    .NPHASE(NP), .ERR_THRESH(ET), .STABLE_THRESH(ST), .INVERT(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .samples(samples), .samples_valid(samples_valid),
    .manual_mode(manual_mode), .phase_sel_in(phase_sel_in), .shift_count_clr(shift_count_clr),
    .data_out(data_out), .data_valid(data_valid), .phase_sel_out(phase_sel_out),
    .phase_err(phase_err), .locked(locked), .shift_count(shift_count)
  );

  always #5 clock = ~clock;

  // Model: every valid word appended to one serial bit stream. A transition
  // at a position means that bit differs from the bit just before it.
  logic [7:0] words[$];
  int m_idx2, m_p, m_err, m_stable, m_shift;
  bit m_v1, m_v2, m_man_prev;

  function automatic bit bit_at(input int pos);
    logic [7:0] w;
    if (pos < 0) return 1'b0;
    w = words[pos / 8];
    return w[pos % 8];
  endfunction

  function automatic bit m_edge(input int k);
    int pos;
    if (m_idx2 < 0) return 1'b0;
    pos = m_idx2 * 8 + k;
    return bit_at(pos) ^ bit_at(pos - 1);
  endfunction

  function automatic bit m_perr();
    return m_v2 && (m_edge(m_p) || m_edge((m_p + 1) % NP));
  endfunction

  function automatic int m_pnext();
    if (manual_mode) return int'(phase_sel_in);
    if (m_err == ET && m_v2) begin
      if (m_edge(m_p)) return (m_p + 1) % NP;
      if (m_edge((m_p + 1) % NP)) return (m_p + NP - 1) % NP;
    end
    return m_p;
  endfunction

  task automatic model_reset();
    words.delete();
    m_idx2 = -1; m_p = 0; m_err = 0; m_stable = 0; m_shift = 0;
    m_v1 = 0; m_v2 = 0; m_man_prev = 0;
  endtask

  task automatic model_step();
    bit pe, lk, auto_shift;
    int pn;
    pe = m_perr();
    lk = (m_stable == ST);
    pn = m_pnext();
    auto_shift = !manual_mode && (pn != m_p);
    if (lk || pn != m_p || (m_man_prev && !manual_mode)) m_err = 0;
    else if (pe && m_err < ET) m_err++;
    if (pe) m_stable = 0;
    else if (m_v2 && m_stable < ST) m_stable++;
    if (shift_count_clr) m_shift = 0;
    else if (auto_shift && m_shift < 255) m_shift++;
    m_man_prev = manual_mode;
    if (m_v1) m_idx2 = words.size() - 1;
    if (samples_valid) words.push_back(samples);
    m_v2 = m_v1;
    m_v1 = samples_valid;
    m_p  = pn;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_data;
    exp_data = (m_v2 && m_idx2 >= 0) ? bit_at(m_idx2 * 8 + m_p) : 1'b0;
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(m_v2));
    chk({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
    chk({tag, ".phase_err"}, 32'(phase_err), 32'(m_perr()));
    chk({tag, ".locked"}, 32'(locked), 32'(m_stable == ST));
    chk({tag, ".phase_sel"}, 32'(phase_sel_out), 32'(m_p));
    chk({tag, ".shift_count"}, 32'(shift_count), 32'(m_shift));
  endtask

  task automatic tick(input string tag);
    @(negedge clock);
    check_all(tag);
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic drive(input logic [7:0] w, input logic v);
    samples = w;
    samples_valid = v;
  endtask

  initial begin
    bit did_clr;
    reset_n = 1'b0; samples = '0; samples_valid = 1'b0; manual_mode = 1'b0;
    phase_sel_in = '0; shift_count_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Edge at bit 0 every cycle from p=0: one step to p=1.
    drive(8'hFF, 1'b1); tick("ff00");
    for (int i = 0; i < 12; i++) begin
      drive((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1);
      tick("ff00");
    end
    chk("ff00.final_phase", 32'(phase_sel_out), 32'd1);
    chk("ff00.final_shift", 32'(shift_count), 32'd1);

    // Alternating nibbles: no transition next to the selected phase, so the link locks.
    for (int i = 0; i < 20; i++) begin
      drive((i % 2 == 0) ? 8'hF0 : 8'h0F, 1'b1);
      tick("nibble");
    end
    chk("nibble.locked", 32'(locked), 32'd1);

    // A valid gap holds the pipeline.
    drive(8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) tick("gap");

    // Both edges set at p=7: the step goes up and wraps to 0.
    manual_mode = 1'b1; phase_sel_in = 3'd7; drive(8'h80, 1'b1); tick("wrap_up.man");
    manual_mode = 1'b0;
    for (int i = 0; i < 12; i++) tick("wrap_up");

    // Only the edge above p=0 is set: the step goes down and wraps to 7. Repeated
    // oscillation then drives shift_count into saturation.
    manual_mode = 1'b1; phase_sel_in = 3'd0; drive(8'h81, 1'b1); tick("wrap_dn.man");
    manual_mode = 1'b0;
    for (int i = 0; i < 1300; i++) tick("sat");
    chk("sat.shift_count", 32'(shift_count), 32'd255);

    // Clear in the same cycle as an automatic shift.
    did_clr = 1'b0;
    for (int i = 0; i < 10 && !did_clr; i++) begin
      if (m_pnext() != m_p) begin
        shift_count_clr = 1'b1;
        did_clr = 1'b1;
      end
      tick("clr_shift");
      shift_count_clr = 1'b0;
    end
    chk("clr_shift.coincident", 32'(did_clr), 32'd1);
    chk("clr_shift.value", 32'(shift_count), 32'd0);

    // Manual phase 5: errors keep occurring but no automatic shift happens.
    manual_mode = 1'b1; phase_sel_in = 3'd5;
    tick("manual");
    chk("manual.phase_next_cycle", 32'(phase_sel_out), 32'd5);
    for (int i = 0; i < 20; i++) begin
      drive(8'($urandom), 1'b1);
      tick("manual");
    end
    chk("manual.no_shift", 32'(shift_count), 32'd0);
    manual_mode = 1'b0;

    // Random traffic with occasional gaps, manual overrides and clears.
    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom), ($urandom_range(0, 9) != 0));
      manual_mode = ($urandom_range(0, 39) == 0);
      phase_sel_in = 3'($urandom);
      shift_count_clr = ($urandom_range(0, 99) == 0);
      tick("random");
    end
    manual_mode = 1'b0; shift_count_clr = 1'b0;

    // Bring err_count to 2, then reset asynchronously in the middle of a cycle.
    manual_mode = 1'b1; phase_sel_in = 3'd0; drive(8'h81, 1'b1); tick("pre_rst.man");
    manual_mode = 1'b0;
    for (int i = 0; i < 20 && m_err != 2; i++) tick("pre_rst");
    chk("pre_rst.err_reached", 32'(m_err == 2), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    tick("rst_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) tick("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
